// File: rtl/e_expand_pipe.sv
// DES-style E-box expansion stage (4G -> 6G bits) with round tagging and an output FIFO.
// Define E_EXPAND_KEYMIX_EN to XOR the round subkey into each expanded word.
module e_expand_pipe #(
    parameter int G     = 8,
    parameter int DEPTH = 2,
    parameter int RW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*G-1:0]           in_data,
    input  logic [6*G-1:0]           in_key,
    input  logic                     round_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6*G-1:0]           out_data,
    output logic [RW-1:0]            out_round,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int W  = 4 * G;
    localparam int X  = 6 * G;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [X-1:0]  w_exp;
    logic [X-1:0]  w_word;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [RW-1:0] w_tag;

    logic [X-1:0]  r_mem_data  [DEPTH];
    logic [RW-1:0] r_mem_round [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [RW-1:0] r_round_ctr;

    // Each 6-bit output group borrows the neighbouring input bit on both sides, wrapping at the ends.
    for (genvar g = 0; g < G; g++) begin : g_grp
        assign w_exp[6*g]        = in_data[(4*g + W - 1) % W];
        assign w_exp[6*g+1 +: 4] = in_data[4*g +: 4];
        assign w_exp[6*g+5]      = in_data[(4*g + 4) % W];
    end

`ifdef E_EXPAND_KEYMIX_EN
    assign w_word = w_exp ^ in_key;
`else
    logic w_unused_key;
    assign w_unused_key = ^in_key;
    assign w_word       = w_exp;
`endif

    assign w_full  = (r_wptr ^ r_rptr) == PW'(DEPTH);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;
    assign w_tag   = round_clr ? '0 : r_round_ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_round_ctr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_round[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr[AW-1:0]]  <= w_word;
                r_mem_round[r_wptr[AW-1:0]] <= w_tag;
                r_wptr                      <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A clear coinciding with an accept tags that word 0, so the next one is 1.
            if (round_clr) begin
                r_round_ctr <= w_push ? RW'(1) : '0;
            end else if (w_push) begin
                r_round_ctr <= r_round_ctr + 1'b1;
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem_data[r_rptr[AW-1:0]];
    assign out_round = r_mem_round[r_rptr[AW-1:0]];
    assign level     = r_wptr - r_rptr;

endmodule

// File: tb/tb_e_expand_pipe.sv
// Scoreboard bench for e_expand_pipe (G=8, DEPTH=2, RW=4); honours E_EXPAND_KEYMIX_EN.
module tb_e_expand_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [47:0] in_key;
    logic        round_clr;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [3:0]  out_round;
    logic [1:0]  level;

    e_expand_pipe #(.G(8), .DEPTH(2), .RW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .round_clr (round_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] d;
        logic [3:0]  r;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [47:0] exp_data;
    logic [3:0]  m_ctr = 4'd0;

`ifdef E_EXPAND_KEYMIX_EN
    localparam logic [47:0] KJUNK = 48'h0;
`else
    localparam logic [47:0] KJUNK = 48'h5A5A_A5A5_3C3C;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model(input logic [31:0] d, input logic [47:0] k);
        logic [47:0] e;
        for (int j = 0; j < 48; j++) begin
            e[j] = d[(4 * (j / 6) + (j % 6) - 1 + 32) % 32];
        end
`ifdef E_EXPAND_KEYMIX_EN
        e = e ^ k;
`endif
        return e;
    endfunction

    // Monitor first (head before this edge), then record what the coming edge accepts.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {16'h0, out_data}, {16'h0, e.d});
                    chk("out_round", {60'h0, out_round}, {60'h0, e.r});
                end
            end
            if (round_clr) begin
                if (in_valid && in_ready) sb.push_back('{exp_data, 4'd0});
                m_ctr = (in_valid && in_ready) ? 4'd1 : 4'd0;
            end else if (in_valid && in_ready) begin
                sb.push_back('{exp_data, m_ctr});
                m_ctr = m_ctr + 4'd1;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [47:0] k, input logic [47:0] e,
                        input logic clr);
        bit done = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        exp_data  = e;
        round_clr = clr;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid  = 1'b0;
        round_clr = 1'b0;
    endtask

    task automatic send_gen(input logic [31:0] d, input logic clr);
        logic [47:0] k;
        k = {$urandom(), $urandom()};
        send(d, k, model(d, k), clr);
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge clk);
            #1;
            if (level == 2'd0 && !out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        round_clr = 1'b0;
        out_ready = 1'b1;
        exp_data  = '0;
        #2;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_level", {62'h0, level}, 64'd0);
        chk("rst_out_data", {16'h0, out_data}, 64'd0);
        chk("rst_out_round", {60'h0, out_round}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'h0, out_valid}, 64'd0);

        // Directed expansion vectors, one-cycle latency
        send(32'h0000_0001, KJUNK, 48'h8000_0000_0002, 1'b0);
        chk("latency_valid", {63'h0, out_valid}, 64'd1);
        chk("latency_data", {16'h0, out_data}, 64'h8000_0000_0002);
        send(32'h8000_0000, KJUNK, 48'h4000_0000_0001, 1'b0);
        send(32'hFFFF_FFFF, KJUNK, 48'hFFFF_FFFF_FFFF, 1'b0);
`ifdef E_EXPAND_KEYMIX_EN
        send(32'h0000_0000, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 1'b0);
`endif
        wait_empty();

        // Round tags: clear, 17 accepts wrap 15->0, then clear coinciding with an accept
        round_clr = 1'b1;
        @(posedge clk);
        #1;
        round_clr = 1'b0;
        for (int i = 0; i < 17; i++) send_gen(32'h1357_9BDF ^ (i * 32'h0101_0101), 1'b0);
        send_gen(32'hDEAD_BEEF, 1'b1);
        send_gen(32'h0F0F_1234, 1'b0);
        wait_empty();

        // Backpressure with DEPTH=2
        out_ready = 1'b0;
        send(32'h0000_0001, KJUNK, 48'h8000_0000_0002, 1'b0);
        send(32'h8000_0000, KJUNK, 48'h4000_0000_0001, 1'b0);
        chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
        chk("bp_level", {62'h0, level}, 64'd2);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_key   = KJUNK;
        exp_data = 48'hFFFF_FFFF_FFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_hold_ready", {63'h0, in_ready}, 64'd0);
        chk("bp_hold_level", {62'h0, level}, 64'd2);
        chk("bp_head_stable", {16'h0, out_data}, 64'h8000_0000_0002);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_rise", {63'h0, in_ready}, 64'd1);
        chk("bp_level_after_pop", {62'h0, level}, 64'd1);
        chk("bp_second_head", {16'h0, out_data}, 64'h4000_0000_0001);
        @(posedge clk);
        #1;
        chk("bp_third_accepted", {62'h0, level}, 64'd1);
        chk("bp_third_head", {16'h0, out_data}, 64'hFFFF_FFFF_FFFF);
        in_valid = 1'b0;

        // Simultaneous push/pop at level 1
        for (int i = 0; i < 10; i++) begin
            send_gen(32'hA5A5_0000 + i * 32'h0011_2233, 1'b0);
            chk("pp_level", {62'h0, level}, 64'd1);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send_gen(32'h0BAD_F00D, 1'b0);
        chk("mid_level_full", {62'h0, level}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("mid_rst_level", {62'h0, level}, 64'd0);
        chk("mid_rst_out_round", {60'h0, out_round}, 64'd0);
        chk("mid_rst_out_data", {16'h0, out_data}, 64'd0);
        sb.delete();
        m_ctr = 4'd0;
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_post_in_ready", {63'h0, in_ready}, 64'd1);
        send(32'h8000_0000, KJUNK, 48'h4000_0000_0001, 1'b0);
        chk("mid_first_tag", {60'h0, out_round}, 64'd0);
        chk("mid_first_valid", {63'h0, out_valid}, 64'd1);
        wait_empty();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
